// File: rtl/fetch_req_ctrl_if.sv
// Fetch-stage bundle: SRAM-like instruction port, decode handoff and redirect inputs.
// The master side is the fetch sequencer; the slave side is the memory/pipeline around it.
interface fetch_req_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        ds_allowin;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adel;

    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] eret_target;

    modport master (
        output inst_req, inst_addr, fs_valid, fs_pc, fs_inst, fs_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
               br_valid, br_target, exc_valid, eret_valid, eret_target
    );

    modport slave (
        input  inst_req, inst_addr, fs_valid, fs_pc, fs_inst, fs_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
               br_valid, br_target, exc_valid, eret_valid, eret_target
    );
endinterface

// File: rtl/fetch_req_ctrl.sv
// Fetch request sequencer: owns the fetch PC, keeps a single instruction request
// outstanding on the SRAM port and buffers the returned word until decode takes it.
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | request fetch_pc (or, if misaligned, raise an ADEL entry instead)
// WAIT  | address accepted, waiting for data_ok (dropped if cancel is set)
// HOLD  | fs_* valid, waiting for ds_allowin
module fetch_req_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic             clk,
    input  logic             reset,
    fetch_req_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [31:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic        r_cancel,     w_cancel_nxt;
    logic        r_br_pend,    w_br_pend_nxt;
    logic [31:0] r_br_target,  w_br_target_nxt;
    logic        r_flush_pend, w_flush_pend_nxt;
    logic [31:0] r_flush_pc,   w_flush_pc_nxt;
    logic        r_fs_valid,   w_fs_valid_nxt;
    logic [31:0] r_fs_pc,      w_fs_pc_nxt;
    logic [31:0] r_fs_inst,    w_fs_inst_nxt;
    logic        r_fs_adel,    w_fs_adel_nxt;

    logic        w_flush;
    logic [31:0] w_flush_target;
    logic        w_aligned;

    // Exception outranks ERET; either one is a flush.
    assign w_flush        = bus.exc_valid | bus.eret_valid;
    assign w_flush_target = bus.exc_valid ? EXC_VECTOR : bus.eret_target;
    assign w_aligned      = (r_fetch_pc[1:0] == 2'b00);

    assign bus.inst_req  = (r_state == S_REQ) && w_aligned;
    assign bus.inst_addr = r_fetch_pc;
    assign bus.fs_valid  = r_fs_valid;
    assign bus.fs_pc     = r_fs_pc;
    assign bus.fs_inst   = r_fs_inst;
    assign bus.fs_adel   = r_fs_adel;

    // Next-state and register-update logic for the fetch sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_cancel_nxt     = r_cancel;
        w_br_pend_nxt    = r_br_pend;
        w_br_target_nxt  = r_br_target;
        w_flush_pend_nxt = r_flush_pend;
        w_flush_pc_nxt   = r_flush_pc;
        w_fs_valid_nxt   = r_fs_valid;
        w_fs_pc_nxt      = r_fs_pc;
        w_fs_inst_nxt    = r_fs_inst;
        w_fs_adel_nxt    = r_fs_adel;

        // A taken branch only redirects after the delay slot is handed to decode;
        // the HOLD acceptance path below consumes (and overrides) this.
        if (bus.br_valid && !w_flush) begin
            w_br_pend_nxt   = 1'b1;
            w_br_target_nxt = bus.br_target;
        end

        case (r_state)
            S_REQ: begin
                if (!w_aligned) begin
                    if (w_flush) begin
                        w_fetch_pc_nxt = w_flush_target;
                        w_br_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt    = S_HOLD;
                        w_fs_valid_nxt = 1'b1;
                        w_fs_adel_nxt  = 1'b1;
                        w_fs_inst_nxt  = 32'h0;
                        w_fs_pc_nxt    = r_fetch_pc;
                    end
                end else if (bus.inst_addr_ok) begin
                    w_state_nxt = S_WAIT;
                    // The request being handed off is stale if any flush is seen
                    // now or was parked while addr_ok was low.
                    if (w_flush) begin
                        w_cancel_nxt     = 1'b1;
                        w_fetch_pc_nxt   = w_flush_target;
                        w_flush_pend_nxt = 1'b0;
                        w_br_pend_nxt    = 1'b0;
                    end else if (r_flush_pend) begin
                        w_cancel_nxt     = 1'b1;
                        w_fetch_pc_nxt   = r_flush_pc;
                        w_flush_pend_nxt = 1'b0;
                    end
                end else if (w_flush) begin
                    // Address must stay put until the memory takes it.
                    w_flush_pend_nxt = 1'b1;
                    w_flush_pc_nxt   = w_flush_target;
                    w_br_pend_nxt    = 1'b0;
                end
            end

            S_WAIT: begin
                if (w_flush) begin
                    w_fetch_pc_nxt = w_flush_target;
                    w_br_pend_nxt  = 1'b0;
                    if (bus.inst_data_ok) begin
                        w_cancel_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_cancel_nxt = 1'b1;
                    end
                end else if (bus.inst_data_ok) begin
                    if (r_cancel) begin
                        w_cancel_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_state_nxt    = S_HOLD;
                        w_fs_valid_nxt = 1'b1;
                        w_fs_adel_nxt  = 1'b0;
                        w_fs_inst_nxt  = bus.inst_rdata;
                        w_fs_pc_nxt    = r_fetch_pc;
                    end
                end
            end

            S_HOLD: begin
                if (w_flush) begin
                    w_fetch_pc_nxt = w_flush_target;
                    w_br_pend_nxt  = 1'b0;
                    w_fs_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end else if (bus.ds_allowin) begin
                    w_fs_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                    w_br_pend_nxt  = 1'b0;
                    if (bus.br_valid) begin
                        w_fetch_pc_nxt = bus.br_target;
                    end else if (r_br_pend) begin
                        w_fetch_pc_nxt = r_br_target;
                    end else begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_cancel     <= 1'b0;
            r_br_pend    <= 1'b0;
            r_br_target  <= 32'h0;
            r_flush_pend <= 1'b0;
            r_flush_pc   <= 32'h0;
            r_fs_valid   <= 1'b0;
            r_fs_pc      <= 32'h0;
            r_fs_inst    <= 32'h0;
            r_fs_adel    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_cancel     <= w_cancel_nxt;
            r_br_pend    <= w_br_pend_nxt;
            r_br_target  <= w_br_target_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_flush_pc   <= w_flush_pc_nxt;
            r_fs_valid   <= w_fs_valid_nxt;
            r_fs_pc      <= w_fs_pc_nxt;
            r_fs_inst    <= w_fs_inst_nxt;
            r_fs_adel    <= w_fs_adel_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Bench for fetch_req_ctrl: a directed per-cycle vector table, a reset-mid-WAIT
// sequence, and a randomized run against a program-flow reference model.
module tb_fetch_req_ctrl;

    localparam logic [31:0] RESET_PC   = 32'hbfc00000;
    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fetch_req_ctrl_if bus ();

    fetch_req_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fsv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adel;
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        allowin;
        logic        br;
        logic [31:0] br_tgt;
        logic        exc;
        logic        eret;
        logic [31:0] eret_tgt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input int q, input logic [31:0] a, input int fv,
                                input logic [31:0] p, input logic [31:0] ins, input int ad,
                                input int ao, input int dk, input logic [31:0] rd,
                                input int al, input int br, input logic [31:0] bt,
                                input int ex, input int er, input logic [31:0] et);
        vec_t r;
        r.e_req = (q != 0);   r.e_addr = a;        r.e_fsv = (fv != 0);
        r.e_pc = p;           r.e_inst = ins;      r.e_adel = (ad != 0);
        r.addr_ok = (ao != 0); r.data_ok = (dk != 0); r.rdata = rd;
        r.allowin = (al != 0); r.br = (br != 0);     r.br_tgt = bt;
        r.exc = (ex != 0);    r.eret = (er != 0);  r.eret_tgt = et;
        return r;
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
        bus.ds_allowin   = 1'b0; bus.br_valid     = 1'b0; bus.br_target  = 32'h0;
        bus.exc_valid    = 1'b0; bus.eret_valid   = 1'b0; bus.eret_target = 32'h0;
    endtask

    // random-phase state
    logic        outstanding;
    int          lat;
    logic [31:0] o_addr;
    logic [31:0] exp_pc;
    logic        m_br_pend;
    logic [31:0] m_br_tgt;
    logic        prev_hold_addr;
    logic [31:0] prev_addr;
    logic        prev_flush;
    logic        prev_stall;
    logic [31:0] prev_fs_pc;
    logic [31:0] prev_fs_inst;
    int          n_deliv;

    initial begin
        logic        aok, dok, al, br, ex, er, flush, busy;
        logic [31:0] bt, et, tgt, want_inst;

        n_checks = 0;
        n_errors = 0;
        drive_idle();
        reset = 1'b1;

        // table: expected outputs this cycle | inputs for the coming edge
        //           req addr          fsv pc            inst          adel  ao dk rdata         al br bt            ex er eret_tgt
        vt.push_back(mk(1, 32'hbfc00000, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00000, 0, 32'h0,        32'h0,        0,  0, 1, 32'h24010001, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00000, 1, 32'hbfc00000, 32'h24010001, 0,  0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00004, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00004, 0, 32'h0,        32'h0,        0,  0, 1, 32'h3c1d0001, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00004, 1, 32'hbfc00004, 32'h3c1d0001, 0,  0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00008, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00008, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 1, 32'hbfc00100, 0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00008, 0, 32'h0,        32'h0,        0,  0, 1, 32'h11112222, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00008, 1, 32'hbfc00008, 32'h11112222, 0,  0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00100, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00100, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 1, 32'hdeadbeef, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h80001000));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001000, 0, 32'h0,        32'h0,        0,  0, 1, 32'hcafebabe, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'h80001000, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001000, 0, 32'h0,        32'h0,        0,  0, 1, 32'h8c020000, 0, 0, 32'h0,        0, 0, 32'h0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0, 32'h80001000, 1, 32'h80001000, 32'h8c020000, 0,  0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001000, 1, 32'h80001000, 32'h8c020000, 0,  0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'h80001004, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h80001002));
        vt.push_back(mk(0, 32'h80001002, 0, 32'h0,        32'h0,        0,  0, 1, 32'h0badf00d, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001002, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001002, 1, 32'h80001002, 32'h0,        1,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'h80001002, 1, 32'h80001002, 32'h0,        1,  0, 0, 32'h0,        1, 1, 32'hbfc00200, 0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00200, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00200, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 1, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 1, 32'h00000001, 0, 0, 32'h0,        0, 0, 32'h0));
        vt.push_back(mk(0, 32'hbfc00380, 1, 32'hbfc00380, 32'h00000001, 0,  0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0));
        vt.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0));

        // reset values while reset is held
        @(negedge clk);
        @(negedge clk);
        check("rst fs_valid",  32'(bus.fs_valid), 32'h0);
        check("rst fs_pc",     bus.fs_pc,         32'h0);
        check("rst fs_inst",   bus.fs_inst,       32'h0);
        check("rst fs_adel",   32'(bus.fs_adel),  32'h0);
        check("rst inst_addr", bus.inst_addr,     RESET_PC);
        reset = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            check($sformatf("row%0d inst_req", i),  32'(bus.inst_req), 32'(vt[i].e_req));
            check($sformatf("row%0d inst_addr", i), bus.inst_addr,     vt[i].e_addr);
            check($sformatf("row%0d fs_valid", i),  32'(bus.fs_valid), 32'(vt[i].e_fsv));
            if (vt[i].e_fsv) begin
                check($sformatf("row%0d fs_pc", i),   bus.fs_pc,        vt[i].e_pc);
                check($sformatf("row%0d fs_inst", i), bus.fs_inst,      vt[i].e_inst);
                check($sformatf("row%0d fs_adel", i), 32'(bus.fs_adel), 32'(vt[i].e_adel));
            end
            bus.inst_addr_ok = vt[i].addr_ok;  bus.inst_data_ok = vt[i].data_ok;
            bus.inst_rdata   = vt[i].rdata;    bus.ds_allowin   = vt[i].allowin;
            bus.br_valid     = vt[i].br;       bus.br_target    = vt[i].br_tgt;
            bus.exc_valid    = vt[i].exc;      bus.eret_valid   = vt[i].eret;
            bus.eret_target  = vt[i].eret_tgt;
        end

        // reset asserted in the middle of a WAIT cycle
        @(negedge clk);
        bus.inst_addr_ok = 1'b1;
        @(negedge clk);
        bus.inst_addr_ok = 1'b0;
        check("midwait inst_req", 32'(bus.inst_req), 32'h0);
        #2 reset = 1'b1;
        #1;
        check("midwait rst fs_valid",  32'(bus.fs_valid), 32'h0);
        check("midwait rst fs_pc",     bus.fs_pc,         32'h0);
        check("midwait rst fs_inst",   bus.fs_inst,       32'h0);
        check("midwait rst fs_adel",   32'(bus.fs_adel),  32'h0);
        check("midwait rst inst_addr", bus.inst_addr,     RESET_PC);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-rst inst_req",  32'(bus.inst_req), 32'h1);
        check("post-rst inst_addr", bus.inst_addr,     RESET_PC);

        // randomized run against a program-order model
        outstanding = 1'b0; lat = 0; o_addr = 32'h0;
        exp_pc = RESET_PC; m_br_pend = 1'b0; m_br_tgt = 32'h0;
        prev_hold_addr = 1'b0; prev_addr = 32'h0; prev_flush = 1'b0;
        prev_stall = 1'b0; prev_fs_pc = 32'h0; prev_fs_inst = 32'h0; n_deliv = 0;

        for (int c = 0; c < 4000; c++) begin
            if (c != 0) @(negedge clk);

            if (prev_hold_addr) begin
                check("rnd addr held inst_req", 32'(bus.inst_req), 32'h1);
                check("rnd addr held inst_addr", bus.inst_addr, prev_addr);
            end
            if (prev_flush)
                check("rnd fs_valid after flush", 32'(bus.fs_valid), 32'h0);
            else if (prev_stall) begin
                check("rnd stall fs_valid", 32'(bus.fs_valid), 32'h1);
                check("rnd stall fs_pc", bus.fs_pc, prev_fs_pc);
                check("rnd stall fs_inst", bus.fs_inst, prev_fs_inst);
            end

            busy = outstanding;
            dok  = 1'b0;
            if (outstanding) begin
                if (lat <= 1) begin
                    dok = 1'b1;
                    outstanding = 1'b0;
                end else begin
                    lat--;
                end
            end
            bus.inst_data_ok = dok;
            bus.inst_rdata   = dok ? mem(o_addr) : $urandom;

            aok = ($urandom_range(0, 99) < 60);
            if (bus.inst_req) begin
                check("rnd single outstanding", 32'(busy), 32'h0);
                check("rnd req aligned", 32'(bus.inst_addr[1:0]), 32'h0);
            end
            if (bus.inst_req && aok) begin
                outstanding = 1'b1;
                lat         = $urandom_range(1, 3);
                o_addr      = bus.inst_addr;
            end
            bus.inst_addr_ok = aok;

            al = ($urandom_range(0, 99) < 60);
            br = ($urandom_range(0, 99) < 4);
            ex = ($urandom_range(0, 99) < 1);
            er = ($urandom_range(0, 99) < 2);
            bt = 32'hbfc00000 | (32'($urandom_range(0, 16383)) << 2);
            et = 32'h80000000 | (32'($urandom_range(0, 16383)) << 2)
                 | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0);
            flush = ex | er;
            tgt   = ex ? EXC_VECTOR : et;

            if (bus.fs_valid && al) begin
                want_inst = (exp_pc[1:0] != 2'b00) ? 32'h0 : mem(exp_pc);
                check("rnd deliver fs_pc", bus.fs_pc, exp_pc);
                check("rnd deliver fs_adel", 32'(bus.fs_adel), 32'(exp_pc[1:0] != 2'b00));
                check("rnd deliver fs_inst", bus.fs_inst, want_inst);
                n_deliv++;
                if (br)             exp_pc = bt;
                else if (m_br_pend) exp_pc = m_br_tgt;
                else                exp_pc = exp_pc + 32'd4;
                m_br_pend = 1'b0;
            end else if (br && !flush) begin
                m_br_pend = 1'b1;
                m_br_tgt  = bt;
            end
            if (flush) begin
                exp_pc    = tgt;
                m_br_pend = 1'b0;
            end

            prev_hold_addr = bus.inst_req && !aok;
            prev_addr      = bus.inst_addr;
            prev_flush     = flush;
            prev_stall     = bus.fs_valid && !al;
            prev_fs_pc     = bus.fs_pc;
            prev_fs_inst   = bus.fs_inst;

            bus.ds_allowin  = al;
            bus.br_valid    = br;
            bus.br_target   = br ? bt : $urandom;
            bus.exc_valid   = ex;
            bus.eret_valid  = er;
            bus.eret_target = et;
        end
        @(negedge clk);
        drive_idle();
        check("rnd progress", 32'(n_deliv > 100), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
- Fetch-stage sequencer between the next-PC logic and an SRAM-like instruction port (req / addr_ok / data_ok).
- Holds the fetch PC, issues one instruction request at a time and buffers the returned word until decode accepts it.
- Applies branch redirects after the delay slot. Applies exception and ERET redirects immediately, discarding stale responses.
- Replaces the direct combinational drive of inst_sram_addr from nextpc.

Parameters:
RESET_PC, 32'hbfc00000, fetch address after reset
EXC_VECTOR, 32'hbfc00380, target on exc_valid

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
inst_req  output  1  instruction request valid
inst_addr  output  32  request address
inst_addr_ok  input  1  address accepted this cycle
inst_data_ok  input  1  read data valid this cycle
inst_rdata  input  32  read data
ds_allowin  input  1  decode accepts fs_* this cycle
fs_valid  output  1  fs_pc/fs_inst valid
fs_pc  output  32  PC of buffered instruction
fs_inst  output  32  buffered instruction
fs_adel  output  1  buffered entry is a misaligned-fetch fault
br_valid  input  1  one-cycle pulse: branch taken
br_target  input  32  branch/jump target
exc_valid  input  1  one-cycle pulse: exception flush
eret_valid  input  1  one-cycle pulse: ERET flush
eret_target  input  32  EPC value

Behaviour:
- Reset (async): state=REQ, fetch_pc=RESET_PC, cancel=0, br_pend=0, fs_valid=0, fs_pc=0, fs_inst=0, fs_adel=0.
- inst_req=1 only in REQ with fetch_pc[1:0]==0. inst_addr=fetch_pc in all states.
- REQ state:
  - Misaligned fetch_pc: no request. Next cycle HOLD with fs_valid=1, fs_adel=1, fs_inst=0, fs_pc=fetch_pc.
  - Aligned fetch_pc: on inst_addr_ok go to WAIT. inst_addr must not change while inst_req=1 and inst_addr_ok=0.
- WAIT state: on inst_data_ok:
  - cancel=1: drop the data, clear cancel, go to REQ.
  - cancel=0: register inst_rdata into fs_inst, fs_pc=fetch_pc, fs_valid=1, go to HOLD.
- HOLD state: fs_valid stays 1 until ds_allowin=1. On acceptance, fs_valid=0 next cycle and the state goes to REQ. fetch_pc becomes br_target_q if br_pend, else fetch_pc+4. br_pend is cleared.
- Latency: data_ok in cycle N gives fs_valid in N+1. Acceptance in cycle M gives a new request in M+1, so sustained throughput is at most 1 instruction per 3 cycles (single outstanding).
- br_valid: latch br_target_q=br_target and set br_pend. The in-flight or held instruction is the delay slot: it is delivered, not cancelled.
- exc_valid / eret_valid are flushes. Priority: exc > eret > branch. On a flush:
  - fetch_pc=EXC_VECTOR or eret_target.
  - br_pend cleared.
  - fs_valid=0 next cycle.
- Flush handling by state:
  - HOLD: go to REQ.
  - WAIT without same-cycle data_ok: set cancel.
  - WAIT with same-cycle data_ok: data dropped, go to REQ.
  - REQ with an outstanding aligned request and no addr_ok: keep the old address until addr_ok, then go to WAIT with cancel=1. Only then does fetch_pc take the flush target.
  - Implement this with a flush_pend/flush_pc pair; the flush target is applied when the cancelled request is handed off.
- Simultaneous events:
  - Flush together with ds_allowin: the flush wins, and the held instruction is still consumed by decode.
  - br_valid together with ds_allowin in HOLD: the next fetch_pc is br_target directly.
  - A flush arriving while cancel=1 only updates the target.
- Arithmetic: fetch_pc+4 is 32-bit with wrap. No other width extension.

Test Plan:
- Reset release; addr_ok immediate, data_ok 1 cycle later with 32'h24010001, ds_allowin=1 -> first inst_addr=bfc00000, fs_pc=bfc00000 valid one cycle after data_ok, next inst_addr=bfc00004.
- br_valid (target bfc00100) while the delay slot bfc00008 is in WAIT -> bfc00008 delivered, then inst_addr=bfc00100.
- exc_valid in WAIT before data_ok -> returned word never appears on fs_*, next inst_addr=bfc00380, cancel clears.
- eret_valid (eret_target 80001000) in REQ while addr_ok is held low 3 cycles -> inst_addr stays at the old PC until addr_ok, its data is discarded, then inst_addr=80001000.
- eret_target=80001002 -> inst_req stays 0, fs_valid=1 with fs_adel=1, fs_pc=80001002, fs_inst=0.
- ds_allowin low 4 cycles in HOLD -> fs_* stable, inst_req=0, no new request until acceptance. Assert reset mid-WAIT -> all outputs take their reset values immediately.
